// File: rtl/mem_latency_model_if.sv
// Request/response channel between the cache controller's miss/writeback
// port and mem_latency_model. Optional MEM_RANGE_CHECK_EN adds resp_err.
interface mem_latency_model_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
`ifdef MEM_RANGE_CHECK_EN
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata
    );
`endif
endinterface

// File: rtl/mem_latency_model.sv
// Single-ported word memory with configurable read/write latency.
// One request in flight: IDLE accepts, WAIT counts down, RESP pulses.
// Optional feature: define MEM_RANGE_CHECK_EN to flag out-of-range or
// misaligned addresses on resp_err and suppress the access.
module mem_latency_model #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    mem_latency_model_if.slave  bus,
    output logic                busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [IDX-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                err_q, err_d;
    logic                mem_we;

    // Contents start at zero once at time 0; reset never touches them.
    logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
    logic resp_err_q, resp_err_d;
    logic addr_err;

    // Upper bits beyond the array or nonzero byte offset make the address illegal.
    assign addr_err = (|(bus.req_addr >> (OFF + IDX))) || (|(bus.req_addr & LOW_MASK));
    assign bus.resp_err = resp_err_q;
`else
    logic addr_err;
    logic unused_addr_bits;

    // Without range checking, addresses wrap and the offset bits are don't-care.
    assign addr_err         = 1'b0;
    assign unused_addr_bits = ^bus.req_addr;
`endif

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign busy           = (state_q != IDLE);

    // Next-state logic: accept in IDLE, count down in WAIT, access on the last WAIT edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        err_d        = err_q;
        resp_rdata_d = resp_rdata_q;
        mem_we       = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    idx_d   = bus.req_addr[OFF+IDX-1:OFF];
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    err_d   = addr_err;
                    cnt_d   = bus.req_write ? 8'(WRITE_LAT - 1) : 8'(READ_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    if (write_q) begin
                        mem_we       = !err_q;
                        resp_rdata_d = '0;
                    end else begin
                        resp_rdata_d = err_q ? '0 : mem[idx_q];
                    end
`ifdef MEM_RANGE_CHECK_EN
                    resp_err_d = err_q;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and latched-request registers; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            err_q        <= 1'b0;
            resp_rdata_q <= '0;
`ifdef MEM_RANGE_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            err_q        <= err_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef MEM_RANGE_CHECK_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    // Byte-lane write into the array at the access edge.
    // NOTE: the array has no reset so it maps onto RAM and survives reset_n.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wstrb_q[k]) begin
                    mem[idx_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_latency_model.sv
// Directed bench for mem_latency_model with default parameters.
// Expectations follow MEM_RANGE_CHECK_EN when the macro is defined.
module tb_mem_latency_model;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int READ_LAT  = 4;
    localparam int WRITE_LAT = 2;
    localparam int TIMEOUT   = 50;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    always #5 clock = ~clock;

    mem_latency_model_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_latency_model #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus),
        .busy   (busy)
    );

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_err();
`ifdef MEM_RANGE_CHECK_EN
        return bus.resp_err;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request, return response data, error flag and latency in edges.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        n = 0;
        while (!bus.req_ready && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            check({name, "_accept_timeout"}, 0, 1);
            bus.req_valid = 1'b0;
            rdata = 'x;
            err   = 1'bx;
            lat   = -1;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        bus.req_wstrb = ~wstrb;
        check({name, "_ready_low"}, bus.req_ready, 0);
        check({name, "_busy_high"}, busy, 1);
        lat = 0;
        while (!bus.resp_valid && lat < TIMEOUT) begin
            @(negedge clock);
            lat++;
        end
        rdata = bus.resp_rdata;
        err   = get_err();
    endtask

    vec_t        vecs[11];
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rt[2];
    logic [31:0] rd[2];
    int          n_resp;
    int          accepts;
    bit          drop_next;
    int          pulses;

    initial begin
        vecs[0]  = '{"rd_0_init",     1'b0, 32'h0,    32'h0,        4'h0, 32'h0,                      1'b0};
        vecs[1]  = '{"wr_10_full",    1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,                      1'b0};
        vecs[2]  = '{"rd_10_full",    1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF,               1'b0};
        vecs[3]  = '{"wr_10_strb5",   1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,                      1'b0};
        vecs[4]  = '{"rd_10_merged",  1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44,               1'b0};
        vecs[5]  = '{"wr_10_strb0",   1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,                      1'b0};
        vecs[6]  = '{"rd_10_unchg",   1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44,               1'b0};
        vecs[7]  = '{"wr_1000_wrap",  1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 32'h0,                      RC};
        vecs[8]  = '{"rd_0_wrap",     1'b0, 32'h0,    32'h0,        4'h0, RC ? 32'h0 : 32'h5A5A5A5A,  1'b0};
        vecs[9]  = '{"rd_13_misalgn", 1'b0, 32'h13,   32'h0,        4'h0, RC ? 32'h0 : 32'hDE22BE44,  RC};
        vecs[10] = '{"wr_ffc_strbA",  1'b1, 32'hFFC,  32'h01020304, 4'hA, 32'h0,                      1'b0};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", bus.req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_err", get_err(), 0);
        reset_n = 1'b1;

        // Table-driven single transactions.
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].name, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                    rdata, err, lat);
            check({vecs[i].name, "_latency"}, lat, vecs[i].write ? WRITE_LAT : READ_LAT);
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
            @(negedge clock);
            check({vecs[i].name, "_pulse_one_cycle"}, bus.resp_valid, 0);
            check({vecs[i].name, "_ready_again"}, bus.req_ready, 1);
            check({vecs[i].name, "_rdata_hold"}, bus.resp_rdata, vecs[i].exp_rdata);
        end

        run_txn("rd_ffc", 1'b0, 32'hFFC, 32'h0, 4'h0, rdata, err, lat);
        check("rd_ffc_rdata", rdata, 32'h01000300);

        // Request held through WAIT with changing address: second is accepted only after ready.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h10;
        check("hold_ready_pre", bus.req_ready, 1);
        @(posedge clock);
        n_resp    = 0;
        accepts   = 1;
        drop_next = 1'b0;
        rt[0] = -1; rt[1] = -1; rd[0] = 'x; rd[1] = 'x;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (drop_next) begin
                bus.req_valid = 1'b0;
                drop_next     = 1'b0;
            end
            if (k == 0) begin
                bus.req_addr  = 32'hFFC;
                bus.req_wdata = 32'h12345678;
            end
            if (bus.resp_valid && n_resp < 2) begin
                rt[n_resp] = k;
                rd[n_resp] = bus.resp_rdata;
                n_resp++;
            end
            if (bus.req_valid && bus.req_ready) begin
                accepts++;
                drop_next = 1'b1;
            end
        end
        check("hold_accepts", accepts, 2);
        check("hold_resp_count", n_resp, 2);
        check("hold_first_lat", rt[0], READ_LAT);
        check("hold_spacing", rt[1] - rt[0], READ_LAT + 2);
        check("hold_first_data", rd[0], 32'hDE22BE44);
        check("hold_second_data", rd[1], 32'h01000300);

        // Reset one cycle after accepting a write, before its access edge.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_wstrb = 4'hF;
        check("abort_ready_pre", bus.req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("abort_busy_pre", busy, 1);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy_low", busy, 0);
        check("abort_ready_high", bus.req_ready, 1);
        pulses = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus.resp_valid) pulses++;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (bus.resp_valid) pulses++;
        end
        check("abort_no_resp", pulses, 0);
        run_txn("rd_20_after_abort", 1'b0, 32'h20, 32'h0, 4'h0, rdata, err, lat);
        check("rd_20_after_abort_rdata", rdata, 32'h0);
        check("rd_20_after_abort_latency", lat, READ_LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_latency_model.md
Name: mem_latency_model

Overview:
- Parametrised successor of the single-cycle data-side main memory behind the cache controller.
- Single-ported word memory with configurable data width, depth and separate read/write latency.
- Byte-strobed writes; valid/ready request channel and one-cycle response pulse.
- Sits between the cache controller's miss/writeback port and nothing else; lets the pipeline be exercised against realistic multi-cycle memory.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8, power of two.
- ADDR_W, 32, byte address width.
- DEPTH, 1024, number of words; power of two.
- READ_LAT, 4, cycles from request acceptance to read response; legal range 1..255.
- WRITE_LAT, 2, cycles from request acceptance to write response; legal range 1..255.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte write enables
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  read data, valid while resp_valid
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, busy=0, latched request cleared.
  - Array contents are NOT reset; they are zero-initialised at time 0 only.
- Address decode:
  - Word index = req_addr[OFF+IDX-1:OFF], where OFF=log2(DATA_W/8) and IDX=log2(DEPTH).
  - Low OFF bits are ignored; upper bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE). busy = !req_ready.
  - IDLE: req_valid&&req_ready at an edge latches write/addr/wdata/wstrb and loads counter = LAT-1, where LAT is WRITE_LAT if write, else READ_LAT. Next state is WAIT.
  - WAIT: if counter==0, perform the access at this edge and go to RESP; else decrement counter.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE at the next edge.
- Latency and throughput:
  - resp_valid is high in the cycle following the LAT-th edge after the acceptance edge.
  - Earliest next acceptance is at edge LAT+2, giving one transaction per LAT+2 cycles.
  - No pipelining and no queueing.
- Read: resp_rdata = memory[index], registered at the access edge. It holds its value after resp_valid drops until the next response.
- Write:
  - Each byte lane k with req_wstrb[k]=1 is updated at the access edge; other lanes are unchanged.
  - resp_rdata = 0 on write responses.
  - wstrb==0 leaves memory unchanged but still produces a response.
- Request inputs are sampled only at the acceptance edge; changes during WAIT/RESP have no effect.
- req_valid while req_ready=0 is ignored; the requester must hold it until accepted.
- Reset mid-operation: the transaction is aborted, no response is issued, and a write whose access edge has not occurred leaves memory untouched.
- Read and write to the same word in back-to-back transactions: the read returns the newly written data.

Optional Feature:
- Macro MEM_RANGE_CHECK_EN.
- When defined:
  - Extra output resp_err (1 bit, reset 0) is added, valid with resp_valid.
  - Any req_addr bit above OFF+IDX-1 set, or nonzero low OFF bits (misaligned), gives resp_err=1 with the same latency.
  - The write is suppressed and resp_rdata=0 on an erroring transaction.
- When undefined: there is no resp_err port, addresses wrap silently and misalignment is ignored.

Test Plan:
- Reset, then read addr 0x0 (defaults) -> req_ready low after accept; resp_valid one cycle high 4 cycles after acceptance; resp_rdata=0x00000000; req_ready high again the next cycle.
- Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> resp_valid 2 cycles after accept, rdata 0. Then read 0x10 -> 0xDEADBEEF.
- Write addr 0x10, wdata 0x11223344, wstrb 0x5, then read 0x10 -> 0xDE22BE44. Write with wstrb 0x0 -> the following read still returns 0xDE22BE44.
- Write 0x5A5A5A5A to addr 0x1000 with DEPTH=1024 -> read addr 0x0 returns 0x5A5A5A5A (wrap). With MEM_RANGE_CHECK_EN: resp_err=1 and a read of 0x0 is unchanged.
- Hold req_valid during WAIT while changing req_addr/req_wdata -> only the first request completes; the second is accepted only after req_ready returns; responses are spaced READ_LAT+2 cycles apart.
- Accept a write to 0x20 (data 0xCAFEF00D), assert reset_n low one cycle later -> resp_valid never pulses, busy=0 immediately, and a subsequent read of 0x20 returns the prior value 0x00000000.
